reorder_buffer: RTL and testbench

Eight-entry circular reorder buffer for the out-of-order LC-3b core. It sits between dispatch/issue and the register file. Dispatch allocates an entry and receives a `lc3b_rob_addr` tag. The entry captures its result from the `CDB` broadcast. Completed entries retire strictly in program order to the register file, which clears `regfile_t.busy` when `rob_entry` matches the commit tag.

---
 rtl/reorder_buffer.sv | 132 +++++++++++++
 tb/tb_reorder_buffer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// reorder_buffer: 8-entry circular ROB; CDB capture, tag query, in-order commit
// Revision: 1.0
// ============================================================================
module reorder_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alloc_req,
  input  logic        alloc_regwrite,
  input  logic [2:0]  alloc_dest,
  output logic [2:0]  alloc_tag,
  output logic        alloc_ack,
  output logic        full,
  output logic        empty,
  input  logic [19:0] cdb_in,
  input  logic [2:0]  query_tag,
  output logic        query_ready,
  output logic [15:0] query_data,
  output logic        commit_valid,
  output logic [2:0]  commit_tag,
  output logic        commit_regwrite,
  output logic [2:0]  commit_dest,
  output logic [15:0] commit_data,
  input  logic        flush
);

  localparam int AW = $clog2(DEPTH);

  // CDB layout: {valid, data[15:0], tag[2:0]}
  logic        cdb_valid;
  logic [15:0] cdb_data;
  logic [2:0]  cdb_tag;

  assign cdb_valid = cdb_in[19];
  assign cdb_data  = cdb_in[18:3];
  assign cdb_tag   = cdb_in[2:0];

  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d, regwrite_q, regwrite_d;
  logic [2:0]       dest_q [DEPTH];
  logic [2:0]       dest_d [DEPTH];
  logic [15:0]      data_q [DEPTH];
  logic [15:0]      data_d [DEPTH];

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign alloc_tag = tail_q;
  assign alloc_ack = alloc_req & ~full & ~flush;

  assign commit_valid    = busy_q[head_q] & ready_q[head_q];
  assign commit_tag      = commit_valid ? head_q : '0;
  assign commit_regwrite = commit_valid & regwrite_q[head_q];
  assign commit_dest     = commit_valid ? dest_q[head_q] : '0;
  assign commit_data     = commit_valid ? data_q[head_q] : '0;

  always_comb begin
    query_ready = ready_q[query_tag];
    query_data  = data_q[query_tag];
    if (cdb_valid && (cdb_tag == query_tag)) begin
      query_ready = 1'b1;
      query_data  = cdb_data;
    end
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    regwrite_d = regwrite_q;
    dest_d     = dest_q;
    data_d     = data_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      busy_d  = '0;
      ready_d = '0;
    end else begin
      if (alloc_ack) begin
        busy_d[tail_q]     = 1'b1;
        ready_d[tail_q]    = 1'b0;
        regwrite_d[tail_q] = alloc_regwrite;
        dest_d[tail_q]     = alloc_dest;
        tail_d             = tail_q + 1'b1;
      end
      // Broadcasts to entries that are not in flight are stale and dropped.
      if (cdb_valid && busy_q[cdb_tag]) begin
        ready_d[cdb_tag] = 1'b1;
        data_d[cdb_tag]  = cdb_data;
      end
      if (commit_valid) begin
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end
      count_d = count_q + (AW+1)'(alloc_ack) - (AW+1)'(commit_valid);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      ready_q    <= '0;
      regwrite_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      regwrite_q <= regwrite_d;
      dest_q     <= dest_d;
      data_q     <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for reorder_buffer: directed scenarios plus randomized traffic
// checked against a program-order queue model.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_req = 1'b0, alloc_regwrite = 1'b0;
  logic [2:0]  alloc_dest = '0;
  logic [2:0]  alloc_tag;
  logic        alloc_ack, full, empty;
  logic [19:0] cdb_in = '0;
  logic [2:0]  query_tag = '0;
  logic        query_ready;
  logic [15:0] query_data;
  logic        commit_valid, commit_regwrite;
  logic [2:0]  commit_tag, commit_dest;
  logic [15:0] commit_data;
  logic        flush = 1'b0;

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_regwrite(alloc_regwrite), .alloc_dest(alloc_dest),
    .alloc_tag(alloc_tag), .alloc_ack(alloc_ack), .full(full), .empty(empty),
    .cdb_in(cdb_in), .query_tag(query_tag), .query_ready(query_ready), .query_data(query_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_regwrite(commit_regwrite),
    .commit_dest(commit_dest), .commit_data(commit_data), .flush(flush)
  );

  typedef struct {
    logic [2:0]  tag;
    logic        rw;
    logic [2:0]  dest;
    logic        rdy;
    logic [15:0] data;
  } ent_t;

  ent_t       mq[$];
  logic [2:0] mhead = '0;
  int         n_checks = 0;
  int         n_fail = 0;

  function automatic logic [2:0] m_tail();
    return mhead + 3'(mq.size());
  endfunction

  function automatic logic m_cv();
    if (mq.size() == 0) return 1'b0;
    return mq[0].rdy;
  endfunction

  function automatic logic m_qready(logic [2:0] t);
    if (cdb_in[19] && cdb_in[2:0] == t) return 1'b1;
    foreach (mq[i]) if (mq[i].tag == t) return mq[i].rdy;
    return 1'b0;
  endfunction

  function automatic logic [15:0] m_qdata(logic [2:0] t);
    if (cdb_in[19] && cdb_in[2:0] == t) return cdb_in[18:3];
    foreach (mq[i]) if (mq[i].tag == t) return mq[i].data;
    return 16'h0;
  endfunction

  task automatic set_cdb(input logic v, input logic [2:0] t, input logic [15:0] d);
    cdb_in = {v, d, t};
  endtask

  task automatic idle();
    alloc_req = 1'b0; alloc_regwrite = 1'b0; alloc_dest = '0;
    set_cdb(1'b0, 3'd0, 16'h0); query_tag = '0; flush = 1'b0;
  endtask

  // Advance one clock, applying the spec rules to the model with pre-edge inputs.
  task automatic tick();
    logic       ack, cv;
    logic [2:0] t;
    ent_t       e;
    @(posedge clk);
    if (rst || flush) begin
      mq.delete(); mhead = '0;
    end else begin
      cv  = m_cv();
      ack = alloc_req && (mq.size() < 8);
      t   = m_tail();
      if (cdb_in[19])
        foreach (mq[i]) if (mq[i].tag == cdb_in[2:0]) begin mq[i].rdy = 1'b1; mq[i].data = cdb_in[18:3]; end
      if (cv) begin void'(mq.pop_front()); mhead = mhead + 3'd1; end
      if (ack) begin
        e.tag = t; e.rw = alloc_regwrite; e.dest = alloc_dest; e.rdy = 1'b0; e.data = 16'h0;
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    mq.delete(); mhead = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_req = 1'b1; alloc_regwrite = 1'b1; alloc_dest = 3'(i + 1);
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_checks++; if (alloc_tag !== 3'd0 || alloc_ack !== 1'b0) begin n_fail++; $display("FAIL reset_alloc tag=%0d ack=%b exp 0/0", alloc_tag, alloc_ack); end
    n_checks++; if ({commit_valid, commit_tag, commit_regwrite, commit_dest, commit_data} !== 24'h0) begin
      n_fail++; $display("FAIL reset_commit cv=%b tag=%0d rw=%b dest=%0d data=%h exp all 0", commit_valid, commit_tag, commit_regwrite, commit_dest, commit_data); end
    n_checks++; if (query_ready !== 1'b0) begin n_fail++; $display("FAIL reset_query got=%b exp=0", query_ready); end
    // Fill three entries, complete the head, then reset asynchronously mid-cycle.
    alloc_n(3);
    set_cdb(1'b1, 3'd0, 16'h0055); tick(); idle();
    #1;
    n_checks++; if (commit_valid !== 1'b1) begin n_fail++; $display("FAIL premid_cv got=%b exp=1", commit_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty got=%b exp=1", empty); end
    n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_cv got=%b exp=0", commit_valid); end
    mq.delete(); mhead = '0;
    tick();
    rst = 1'b0;
    alloc_req = 1'b1;
    #1;
    n_checks++; if (alloc_tag !== 3'd0 || alloc_ack !== 1'b1) begin n_fail++; $display("FAIL postrst_alloc tag=%0d ack=%b exp 0/1", alloc_tag, alloc_ack); end
    idle();
  endtask

  task automatic test_in_order();
    apply_reset();
    alloc_n(3);
    set_cdb(1'b1, 3'd2, 16'h0003); tick();
    set_cdb(1'b1, 3'd0, 16'h0001);
    #1;
    n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL io_no_bypass cv=%b exp=0", commit_valid); end
    tick();
    set_cdb(1'b1, 3'd1, 16'h0002);
    #1;
    n_checks++; if ({commit_valid, commit_tag, commit_regwrite, commit_dest, commit_data} !== {1'b1, 3'd0, 1'b1, 3'd1, 16'h0001}) begin
      n_fail++; $display("FAIL io_commit0 cv=%b tag=%0d rw=%b dest=%0d data=%h exp 1/0/1/1/0001", commit_valid, commit_tag, commit_regwrite, commit_dest, commit_data); end
    tick();
    set_cdb(1'b0, 3'd0, 16'h0);
    #1;
    n_checks++; if ({commit_valid, commit_tag, commit_dest, commit_data} !== {1'b1, 3'd1, 3'd2, 16'h0002}) begin
      n_fail++; $display("FAIL io_commit1 cv=%b tag=%0d dest=%0d data=%h exp 1/1/2/0002", commit_valid, commit_tag, commit_dest, commit_data); end
    tick();
    #1;
    n_checks++; if ({commit_valid, commit_tag, commit_dest, commit_data} !== {1'b1, 3'd2, 3'd3, 16'h0003}) begin
      n_fail++; $display("FAIL io_commit2 cv=%b tag=%0d dest=%0d data=%h exp 1/2/3/0003", commit_valid, commit_tag, commit_dest, commit_data); end
    tick();
    #1;
    n_checks++; if (empty !== 1'b1 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL io_drained empty=%b cv=%b exp 1/0", empty, commit_valid); end
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      alloc_req = 1'b1; alloc_dest = 3'(i);
      #1;
      n_checks++; if (alloc_tag !== 3'(i) || alloc_ack !== 1'b1) begin n_fail++; $display("FAIL fill_tag%0d tag=%0d ack=%b exp %0d/1", i, alloc_tag, alloc_ack, i); end
      tick();
    end
    #1;
    n_checks++; if (full !== 1'b1 || alloc_ack !== 1'b0) begin n_fail++; $display("FAIL full_reject full=%b ack=%b exp 1/0", full, alloc_ack); end
    set_cdb(1'b1, 3'd0, 16'h00A0);
    tick();
    set_cdb(1'b0, 3'd0, 16'h0);
    #1;
    n_checks++; if (commit_valid !== 1'b1 || commit_tag !== 3'd0 || full !== 1'b1 || alloc_ack !== 1'b0) begin
      n_fail++; $display("FAIL full_commit_cycle cv=%b tag=%0d full=%b ack=%b exp 1/0/1/0", commit_valid, commit_tag, full, alloc_ack); end
    tick();
    #1;
    n_checks++; if (alloc_tag !== 3'd0 || alloc_ack !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL wrap_alloc tag=%0d ack=%b full=%b exp 0/1/0", alloc_tag, alloc_ack, full); end
    tick();
    idle();
    #1;
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL refull got=%b exp=1", full); end
  endtask

  task automatic test_query_stale();
    apply_reset();
    alloc_n(5);
    query_tag = 3'd4;
    #1;
    n_checks++; if (query_ready !== 1'b0) begin n_fail++; $display("FAIL q_pending got=%b exp=0", query_ready); end
    set_cdb(1'b1, 3'd4, 16'hBEEF);
    #1;
    n_checks++; if (query_ready !== 1'b1 || query_data !== 16'hBEEF) begin n_fail++; $display("FAIL q_bypass rdy=%b data=%h exp 1/beef", query_ready, query_data); end
    tick();
    set_cdb(1'b0, 3'd0, 16'h0);
    #1;
    n_checks++; if (query_ready !== 1'b1 || query_data !== 16'hBEEF) begin n_fail++; $display("FAIL q_stored rdy=%b data=%h exp 1/beef", query_ready, query_data); end
    set_cdb(1'b1, 3'd5, 16'h1234);
    tick();
    set_cdb(1'b0, 3'd0, 16'h0);
    alloc_req = 1'b1;
    #1;
    n_checks++; if (alloc_tag !== 3'd5 || alloc_ack !== 1'b1) begin n_fail++; $display("FAIL stale_alloc tag=%0d ack=%b exp 5/1", alloc_tag, alloc_ack); end
    tick();
    idle();
    query_tag = 3'd5;
    #1;
    n_checks++; if (query_ready !== 1'b0) begin n_fail++; $display("FAIL stale_dropped rdy=%b exp=0", query_ready); end
  endtask

  task automatic test_flush();
    apply_reset();
    alloc_n(5);
    set_cdb(1'b1, 3'd0, 16'h0777); tick();
    flush = 1'b1; alloc_req = 1'b1; set_cdb(1'b1, 3'd1, 16'h0888);
    #1;
    n_checks++; if (alloc_ack !== 1'b0 || commit_valid !== 1'b1) begin n_fail++; $display("FAIL flush_cycle ack=%b cv=%b exp 0/1", alloc_ack, commit_valid); end
    tick();
    idle();
    #1;
    n_checks++; if (empty !== 1'b1 || alloc_tag !== 3'd0 || commit_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_flush empty=%b tag=%0d cv=%b exp 1/0/0", empty, alloc_tag, commit_valid); end
    for (int t = 0; t < 8; t++) begin
      query_tag = 3'(t);
      #1;
      n_checks++; if (query_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready%0d got=%b exp=0", t, query_ready); end
    end
  endtask

  task automatic test_random();
    logic       e_cv;
    logic [2:0] ctag;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      alloc_req      = ($urandom_range(0, 3) != 0);
      alloc_regwrite = 1'($urandom);
      alloc_dest     = 3'($urandom);
      ctag           = 3'($urandom);
      if (mq.size() > 0 && $urandom_range(0, 4) != 0) ctag = mq[$urandom_range(0, mq.size() - 1)].tag;
      set_cdb($urandom_range(0, 1) == 1, ctag, 16'($urandom));
      query_tag      = 3'($urandom);
      flush          = ($urandom_range(0, 49) == 0);
      #1;
      e_cv = m_cv();
      n_checks++; if (empty !== (mq.size() == 0) || full !== (mq.size() == 8)) begin
        n_fail++; $display("FAIL rnd_level c=%0d empty=%b full=%b exp size=%0d", c, empty, full, mq.size()); end
      n_checks++; if (alloc_tag !== m_tail() || alloc_ack !== (alloc_req && mq.size() < 8 && !flush)) begin
        n_fail++; $display("FAIL rnd_alloc c=%0d tag=%0d ack=%b exp tag=%0d", c, alloc_tag, alloc_ack, m_tail()); end
      n_checks++; if (commit_valid !== e_cv) begin n_fail++; $display("FAIL rnd_cv c=%0d got=%b exp=%b", c, commit_valid, e_cv); end
      if (e_cv) begin
        n_checks++; if ({commit_tag, commit_regwrite, commit_dest, commit_data} !== {mhead, mq[0].rw, mq[0].dest, mq[0].data}) begin
          n_fail++; $display("FAIL rnd_payload c=%0d tag=%0d rw=%b dest=%0d data=%h exp %0d/%b/%0d/%h", c, commit_tag, commit_regwrite, commit_dest, commit_data, mhead, mq[0].rw, mq[0].dest, mq[0].data); end
      end else begin
        n_checks++; if ({commit_tag, commit_regwrite, commit_dest, commit_data} !== 23'h0) begin
          n_fail++; $display("FAIL rnd_payload_zero c=%0d tag=%0d rw=%b dest=%0d data=%h exp 0", c, commit_tag, commit_regwrite, commit_dest, commit_data); end
      end
      n_checks++; if (query_ready !== m_qready(query_tag)) begin n_fail++; $display("FAIL rnd_qready c=%0d tag=%0d got=%b exp=%b", c, query_tag, query_ready, m_qready(query_tag)); end
      if (m_qready(query_tag)) begin
        n_checks++; if (query_data !== m_qdata(query_tag)) begin n_fail++; $display("FAIL rnd_qdata c=%0d tag=%0d got=%h exp=%h", c, query_tag, query_data, m_qdata(query_tag)); end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full_wrap();
    test_query_stale();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
